multi_cycle_mips: RTL and testbench
===================================

# multi_cycle_mips

Multi-cycle 32-bit MIPS-subset processor core that fetches and executes instructions through a single shared, asynchronous (combinational-read, clocked-write) word memory. Each instruction takes several clock cycles sequenced by one control FSM, reusing one ALU. It is the CPU top of the system; memory sits outside on the `mem_*` bus.

## Interface
- `MEM_WAIT`, default 3: cycles the core holds a read address stable before sampling `mem_read_data`; must be at least 1.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears the core immediately.
- `mem_addr` output 32: byte address; the memory uses bits [11:2].
- `mem_read_data` input 32: read data, valid `MEM_WAIT` cycles after address and read are stable.
- `mem_write_data` output 32: store data.
- `mem_read` output 1: read strobe; the memory drives X when it is low.
- `mem_write` output 1: the memory writes on the rising edge where this is high.

## Operation
- Architectural state:
  - `PC` register.
  - Register file instance `rf` (sub-module `reg_file`) holding array `rf_data[0:31]`; `$0` always reads as 0 and writes to it are ignored.
  - Internal registers `IR`, `MDR`, `A`, `B`, `ALUOut`.
- Instruction set:
  - R-type: `add`, `addu`, `sub`, `subu`, `and`, `or`, `xor`, `nor`, `slt`, `sltu`.
  - I-type: `addi`, `addiu`, `andi`, `ori`, `xori`, `slti`, `lui`, `lw`, `sw`, `beq`, `bne`.
  - J-type: `j`.
- Arithmetic rules:
  - All arithmetic wraps modulo 2^32; no overflow exceptions.
  - `andi`, `ori`, `xori` zero-extend the immediate; all other I-types sign-extend it.
  - `slt` and `slti` compare signed; `sltu` compares unsigned.
- Branch target is PC+4 + (sext(imm)<<2). Jump target is {PC+4[31:28], target, 2'b00}.
- FSM states and transitions:
  - FETCH: `mem_addr`=PC, `mem_read`=1 for `MEM_WAIT` cycles. On the last cycle, IR ← `mem_read_data` and PC ← PC+4.
  - DECODE: A ← rs, B ← rt, ALUOut ← branch target. Next state is chosen by opcode. Undefined opcode or funct acts as a NOP and goes to FETCH.
  - MEMADR: ALUOut ← A+sext(imm). Next is MEMRD for `lw`, MEMWR for `sw`.
  - MEMRD: `mem_addr`=ALUOut, `mem_read`=1 for `MEM_WAIT` cycles; MDR is latched on the last cycle. Next is MEMWB.
  - MEMWB: rt ← MDR. Next is FETCH.
  - MEMWR: `mem_addr`=ALUOut, `mem_write_data`=B, `mem_write`=1 for exactly one cycle. Next is FETCH.
  - EXEC (R-type) / IEXEC (I-type): ALUOut ← result.
  - RWB / IWB: rd or rt ← ALUOut. Next is FETCH.
  - BRANCH: if the condition holds, PC ← ALUOut. Next is FETCH.
  - JUMP: PC ← jump target. Next is FETCH.
- Bus rules:
  - `mem_read` and `mem_write` are never high together.
  - `mem_addr` stays stable for the whole of any strobe.
  - Outside memory states: `mem_read`=0, `mem_write`=0, `mem_addr`=PC.

## Timing
- Reset value while `reset` is high:
  - State FETCH with its wait counter at 0.
  - PC=0; IR, MDR, A, B, ALUOut = 0.
  - `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_write_data`=0.
  - Register file contents cleared to 0.
- The first fetch begins on the first rising edge after `reset` falls.
- Cycle counts, with W=`MEM_WAIT`:
  - R-type / ALU-immediate: W+3.
  - `lw`: 2W+3.
  - `sw`: W+3.
  - `beq`, `bne`, `j`: W+2.
- PC updates on the last FETCH cycle and again in BRANCH or JUMP.
- Register-file writes take effect at the end of the writeback cycle and are visible to the next instruction's DECODE.
- A reset asserted mid-instruction aborts it; any register writeback or memory write not yet clocked is discarded.

## Configuration
- `MULT_EN` defined:
  - Adds HI/LO registers and the instructions `mult` (signed), `multu`, `mfhi`, `mflo`.
  - `mult`/`multu` complete in EXEC: {HI,LO} ← 64-bit product, then go to FETCH.
  - `mfhi`/`mflo` use EXEC → RWB.
  - HI and LO reset to 0.
- `MULT_EN` undefined: these funct codes decode as NOP and no HI/LO hardware exists.

## Structure
- Shared package `mips_pkg` holds:
  - Opcode and funct constants.
  - ALU-operation enum.
  - FSM state enum.
  - `RESET_PC`=32'h0.
- One sub-module, `reg_file`, instance `rf`: 32×32 array `rf_data`, two combinational read ports, one synchronous write port, asynchronous clear.
- The ALU and FSM are inline in `multi_cycle_mips`.

## Test plan
- Reset released, memory word 0 = `addi $9,$0,5`: after W+3 cycles, `rf_data[9]`=5 and PC=4. `mem_read` stays low during reset.
- `sw $9,200($0)` followed by `lw $10,200($0)`: memory word 50 = 5 and `rf_data[10]`=5. `mem_write` is high for exactly one cycle with `mem_addr`=200.
- `beq` taken and not taken, `bne`, and `j` to 0x38: PC follows the target rules, and the loop halts with PC=0x38.
- ALU sweep:
  - `sub` of 0-1 gives 0xFFFFFFFF.
  - `slt` of -1,1 gives 1; `sltu` of the same operands gives 0.
  - `lui 0x1234` gives 0x12340000.
  - `ori 0xFFFF` zero-extends.
  - Writes to `$0` are ignored.
- Arithmetic-sequence program (first term, difference, n terms; sum stored to words 50–51): the stored sum matches the closed-form value, and `$9` holds n.
- `reset` asserted during MEMWR: no memory write occurs, and PC=0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcodes, funct codes, ALU operations and FSM states for the multi-cycle MIPS core.
package mips_pkg;

    localparam logic [31:0] RESET_PC = 32'h0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU, ALU_LUI
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP
    } state_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one clocked write port,
// asynchronous clear. Register $0 reads as zero and ignores writes.
module reg_file (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);
    logic [31:0] rf_data [0:31];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) rf_data[i] <= '0;
        end else if (we_i && (wa_i != 5'd0)) begin
            rf_data[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? '0 : rf_data[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? '0 : rf_data[ra2_i];

endmodule

// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS-subset core: one FSM, one ALU, one shared word memory on mem_*.
// Define MULT_EN to add HI/LO with mult, multu, mfhi and mflo.
module multi_cycle_mips #(
    parameter int MEM_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write
);
    import mips_pkg::*;

    localparam int CW = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   pc_q, ir_q, mdr_q, a_q, b_q, alu_out_q;
`ifdef MULT_EN
    logic [31:0]   hi_q, lo_q;
    logic [63:0]   prod_s, prod_u;
    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
`endif

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_s, imm_z;
    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];
    assign imm_s  = sext16(ir_q[15:0]);
    assign imm_z  = {16'd0, ir_q[15:0]};

    logic [31:0] rd1, rd2, rf_wd;
    logic        rf_we;
    logic [4:0]  rf_wa;

    reg_file rf (
        .clk_i   (clk),
        .reset_i (reset),
        .ra1_i   (rs),
        .ra2_i   (rt),
        .rd1_o   (rd1),
        .rd2_o   (rd2),
        .we_i    (rf_we),
        .wa_i    (rf_wa),
        .wd_i    (rf_wd)
    );

    // Instruction decode: unknown funct/opcode falls back to FETCH (NOP).
    alu_op_e     r_op, i_op;
    logic        r_ok, i_ok;
    logic [31:0] i_imm;
    state_e      dec_state_d;

    always_comb begin
        r_op = ALU_ADD;
        r_ok = 1'b1;
        case (funct)
            F_ADD, F_ADDU: r_op = ALU_ADD;
            F_SUB, F_SUBU: r_op = ALU_SUB;
            F_AND:         r_op = ALU_AND;
            F_OR:          r_op = ALU_OR;
            F_XOR:         r_op = ALU_XOR;
            F_NOR:         r_op = ALU_NOR;
            F_SLT:         r_op = ALU_SLT;
            F_SLTU:        r_op = ALU_SLTU;
`ifdef MULT_EN
            F_MULT, F_MULTU, F_MFHI, F_MFLO: r_op = ALU_ADD;
`endif
            default:       r_ok = 1'b0;
        endcase

        i_op  = ALU_ADD;
        i_ok  = 1'b1;
        i_imm = imm_s;
        case (opcode)
            OP_ADDI, OP_ADDIU: i_op = ALU_ADD;
            OP_SLTI:           i_op = ALU_SLT;
            OP_ANDI: begin i_op = ALU_AND; i_imm = imm_z; end
            OP_ORI:  begin i_op = ALU_OR;  i_imm = imm_z; end
            OP_XORI: begin i_op = ALU_XOR; i_imm = imm_z; end
            OP_LUI:  begin i_op = ALU_LUI; i_imm = imm_z; end
            default:           i_ok = 1'b0;
        endcase

        dec_state_d = S_FETCH;
        case (opcode)
            OP_RTYPE:      dec_state_d = r_ok ? S_EXEC : S_FETCH;
            OP_LW, OP_SW:  dec_state_d = S_MEMADR;
            OP_BEQ, OP_BNE: dec_state_d = S_BRANCH;
            OP_J:          dec_state_d = S_JUMP;
            default:       dec_state_d = i_ok ? S_IEXEC : S_FETCH;
        endcase
    end

    // The single ALU: operands are steered by the current state.
    logic [31:0] alu_a, alu_b, alu_y;
    alu_op_e     alu_op;

    always_comb begin
        alu_a  = a_q;
        alu_b  = b_q;
        alu_op = ALU_ADD;
        case (state_q)
            S_FETCH:  begin alu_a = pc_q; alu_b = 32'd4; end
            S_DECODE: begin alu_a = pc_q; alu_b = {imm_s[29:0], 2'b00}; end
            S_MEMADR: alu_b = imm_s;
            S_EXEC:   alu_op = r_op;
            S_IEXEC:  begin alu_b = i_imm; alu_op = i_op; end
            default:  ;
        endcase

        case (alu_op)
            ALU_ADD:  alu_y = alu_a + alu_b;
            ALU_SUB:  alu_y = alu_a - alu_b;
            ALU_AND:  alu_y = alu_a & alu_b;
            ALU_OR:   alu_y = alu_a | alu_b;
            ALU_XOR:  alu_y = alu_a ^ alu_b;
            ALU_NOR:  alu_y = ~(alu_a | alu_b);
            ALU_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'd0, alu_a < alu_b};
            ALU_LUI:  alu_y = {alu_b[15:0], 16'd0};
            default:  alu_y = '0;
        endcase
    end

    // Strobes are gated by reset so an aborted store never reaches memory.
    always_comb begin
        mem_read       = !reset && ((state_q == S_FETCH) || (state_q == S_MEMRD));
        mem_write      = !reset && (state_q == S_MEMWR);
        mem_addr       = ((state_q == S_MEMRD) || (state_q == S_MEMWR)) ? alu_out_q : pc_q;
        mem_write_data = b_q;

        rf_we = 1'b0;
        rf_wa = rt;
        rf_wd = alu_out_q;
        case (state_q)
            S_RWB:   begin rf_we = 1'b1; rf_wa = rd; end
            S_IWB:   rf_we = 1'b1;
            S_MEMWB: begin rf_we = 1'b1; rf_wd = mdr_q; end
            default: ;
        endcase
    end

    logic br_taken;
    assign br_taken = (opcode == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
`ifdef MULT_EN
            hi_q      <= '0;
            lo_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (cnt_q == CNT_LAST) begin
                        ir_q    <= mem_read_data;
                        pc_q    <= alu_y;
                        cnt_q   <= '0;
                        state_q <= S_DECODE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DECODE: begin
                    a_q       <= rd1;
                    b_q       <= rd2;
                    alu_out_q <= alu_y;
                    state_q   <= dec_state_d;
                end
                S_MEMADR: begin
                    alu_out_q <= alu_y;
                    state_q   <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (cnt_q == CNT_LAST) begin
                        mdr_q   <= mem_read_data;
                        cnt_q   <= '0;
                        state_q <= S_MEMWB;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_EXEC: begin
                    alu_out_q <= alu_y;
                    state_q   <= S_RWB;
`ifdef MULT_EN
                    if (funct == F_MULT) begin
                        {hi_q, lo_q} <= prod_s;
                        state_q      <= S_FETCH;
                    end else if (funct == F_MULTU) begin
                        {hi_q, lo_q} <= prod_u;
                        state_q      <= S_FETCH;
                    end else if (funct == F_MFHI) begin
                        alu_out_q <= hi_q;
                    end else if (funct == F_MFLO) begin
                        alu_out_q <= lo_q;
                    end
`endif
                end
                S_IEXEC: begin
                    alu_out_q <= alu_y;
                    state_q   <= S_IWB;
                end
                S_BRANCH: begin
                    if (br_taken) pc_q <= alu_out_q;
                    state_q <= S_FETCH;
                end
                S_JUMP: begin
                    pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
                    state_q <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_mips.sv
// Directed bench for multi_cycle_mips with a combinational-read word memory model.
`timescale 1ns/1ps
module tb_multi_cycle_mips;
  import mips_pkg::*;

  localparam int W = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr, mem_read_data, mem_write_data;
  logic        mem_read, mem_write;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_cycle_mips #(.MEM_WAIT(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_read_data  (mem_read_data),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write)
  );

  // Memory model: async read, clocked write, bench-side clear/load port.
  logic [31:0] mem [0:1023];
  logic        mem_clr = 1'b0;
  logic        load_en = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  assign mem_read_data = mem_read ? mem[mem_addr[11:2]] : 'x;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (mem_write) begin
      mem[mem_addr[11:2]] <= mem_write_data;
    end
  end

  // Bus monitor.
  int          wr_cnt = 0;
  logic [31:0] wr_addr = '0;
  int          bus_err = 0;
  logic        prev_rd = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (mem_read && mem_write) bus_err++;
    if (mem_read && prev_rd && (mem_addr != prev_addr)) bus_err++;
    if (mem_write) begin
      wr_cnt++;
      wr_addr = mem_addr;
    end
    prev_rd   = mem_read;
    prev_addr = mem_addr;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] f);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [31:0] addr);
    return {OP_J, addr[27:2]};
  endfunction

  logic [31:0] prog [$];

  task automatic load_word(input int idx, input logic [31:0] w);
    load_addr = 10'(idx);
    load_data = w;
    load_en   = 1'b1;
    @(posedge clk);
    #1;
    load_en   = 1'b0;
  endtask

  task automatic load_prog();
    mem_clr = 1'b1;
    @(posedge clk);
    #1;
    mem_clr = 1'b0;
    foreach (prog[i]) load_word(i, prog[i]);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input logic [31:0] hpc, input int budget, input string tag);
    bit done = 1'b0;
    logic [31:0] hins = jtype(hpc);
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (dut.state_q == S_FETCH && dut.pc_q == hpc && dut.ir_q == hins) done = 1'b1;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  int          wr_base;
  logic [31:0] exp_rf [0:20];
  int          a_t, d_t, n_t, sum_exp;

  initial begin
    reset = 1'b1;

    // ---- Program A: addi / sw / lw with cycle-exact checks ----
    prog.delete();
    prog.push_back(itype(OP_ADDI, 0, 9, 16'd5));
    prog.push_back(itype(OP_SW, 0, 9, 16'd200));
    prog.push_back(itype(OP_LW, 0, 10, 16'd200));
    prog.push_back(jtype(32'd12));
    load_prog();

    check("rst_pc", dut.pc_q, 32'h0);
    check("rst_ir", dut.ir_q, 32'h0);
    check("rst_aluout", dut.alu_out_q, 32'h0);
    check("rst_mdr", dut.mdr_q, 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(S_FETCH));
    check("rst_cnt", 32'(dut.cnt_q), 32'h0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);

    wr_base = wr_cnt;
    release_reset();
    step(W);
    check("a_fetch_pc", dut.pc_q, 32'd4);
    step(2);
    check("a_addi_early", dut.rf.rf_data[9], 32'd0);
    step(1);
    check("a_addi_r9", dut.rf.rf_data[9], 32'd5);
    check("a_addi_pc", dut.pc_q, 32'd4);
    step(W + 2);
    check("a_sw_state", 32'(dut.state_q), 32'(S_MEMWR));
    check("a_sw_strobe", {31'd0, mem_write}, 32'd1);
    check("a_sw_addr", mem_addr, 32'd200);
    check("a_sw_data", mem_write_data, 32'd5);
    step(1);
    check("a_mem50", mem[50], 32'd5);
    step(2 * W + 2);
    check("a_lw_early", dut.rf.rf_data[10], 32'd0);
    step(1);
    check("a_lw_r10", dut.rf.rf_data[10], 32'd5);
    step(W + 1);
    check("a_j_state", 32'(dut.state_q), 32'(S_JUMP));
    check("a_j_pc4", dut.pc_q, 32'd16);
    step(1);
    check("a_j_pc", dut.pc_q, 32'd12);
    check("a_wr_count", 32'(wr_cnt - wr_base), 32'd1);
    check("a_wr_addr", wr_addr, 32'd200);

    // ---- Program B: beq taken / not taken, bne, j ----
    reset = 1'b1;
    prog.delete();
    prog.push_back(itype(OP_ADDI, 0, 1, 16'd3));   // 0
    prog.push_back(itype(OP_ADDI, 0, 2, 16'd3));   // 4
    prog.push_back(itype(OP_BEQ, 1, 2, 16'd2));    // 8  -> 20
    prog.push_back(itype(OP_ADDI, 0, 3, 16'd1));   // 12
    prog.push_back(itype(OP_ADDI, 0, 3, 16'd2));   // 16
    prog.push_back(itype(OP_ADDI, 0, 4, 16'd7));   // 20
    prog.push_back(itype(OP_BEQ, 1, 4, 16'd5));    // 24 not taken
    prog.push_back(itype(OP_BNE, 1, 4, 16'd1));    // 28 -> 36
    prog.push_back(itype(OP_ADDI, 0, 5, 16'd9));   // 32
    prog.push_back(itype(OP_ADDI, 0, 6, 16'd6));   // 36
    prog.push_back(jtype(32'h38));                 // 40
    prog.push_back(itype(OP_ADDI, 0, 7, 16'd1));   // 44
    prog.push_back(itype(OP_ADDI, 0, 8, 16'd1));   // 48
    prog.push_back(itype(OP_ADDI, 0, 8, 16'd2));   // 52
    prog.push_back(jtype(32'h38));                 // 56
    load_prog();
    check("b_rst_mem_read", {31'd0, mem_read}, 32'd0);
    release_reset();
    run_to_halt(32'h38, 400, "b_halt");
    check("b_pc", dut.pc_q, 32'h38);
    check("b_r3_skipped", dut.rf.rf_data[3], 32'd0);
    check("b_r4", dut.rf.rf_data[4], 32'd7);
    check("b_r5_skipped", dut.rf.rf_data[5], 32'd0);
    check("b_r6", dut.rf.rf_data[6], 32'd6);
    check("b_r7_skipped", dut.rf.rf_data[7], 32'd0);
    check("b_r8_skipped", dut.rf.rf_data[8], 32'd0);

    // ---- Program C: ALU sweep ----
    reset = 1'b1;
    prog.delete();
    prog.push_back(itype(OP_ADDI, 0, 1, 16'd1));
    prog.push_back(rtype(0, 1, 2, F_SUB));
    prog.push_back(rtype(2, 1, 3, F_SLT));
    prog.push_back(rtype(2, 1, 4, F_SLTU));
    prog.push_back(itype(OP_LUI, 0, 5, 16'h1234));
    prog.push_back(itype(OP_ORI, 0, 6, 16'hFFFF));
    prog.push_back(itype(OP_ADDI, 0, 0, 16'd5));
    prog.push_back(rtype(0, 1, 7, F_ADD));
    prog.push_back(rtype(0, 0, 8, F_NOR));
    prog.push_back(itype(OP_XORI, 6, 9, 16'h00FF));
    prog.push_back(itype(OP_ANDI, 2, 10, 16'h8001));
    prog.push_back(itype(OP_SLTI, 1, 11, 16'hFFFF));
    prog.push_back(itype(OP_SLTI, 2, 12, 16'h0000));
    prog.push_back(itype(OP_ADDI, 0, 13, 16'hFFFD));
    prog.push_back(rtype(5, 6, 14, F_ADDU));
    prog.push_back(rtype(14, 6, 15, F_AND));
    prog.push_back(rtype(5, 1, 16, F_OR));
    prog.push_back(rtype(14, 5, 17, F_XOR));
    prog.push_back(rtype(1, 13, 18, F_SUBU));
    prog.push_back(itype(6'h0B, 0, 19, 16'd5));
    prog.push_back(rtype(1, 1, 20, 6'h3F));
    prog.push_back(jtype(32'd84));
    exp_rf = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h12340000, 32'h0000FFFF,
               32'h1, 32'hFFFFFFFF, 32'h0000FF00, 32'h00008001, 32'h0, 32'h1,
               32'hFFFFFFFD, 32'h1234FFFF, 32'h0000FFFF, 32'h12340001, 32'h0000FFFF,
               32'h4, 32'h0, 32'h0};
    load_prog();
    release_reset();
    run_to_halt(32'd84, 600, "c_halt");
    for (int r = 0; r <= 20; r++) check($sformatf("c_alu_r%0d", r), dut.rf.rf_data[r], exp_rf[r]);

    // ---- Program D: arithmetic-sequence sum ----
    reset = 1'b1;
    a_t = 7;
    d_t = 3;
    n_t = 10;
    sum_exp = n_t * a_t + d_t * n_t * (n_t - 1) / 2;
    prog.delete();
    prog.push_back(itype(OP_ADDI, 0, 1, 16'(a_t)));  // 0
    prog.push_back(itype(OP_ADDI, 0, 2, 16'(d_t)));  // 4
    prog.push_back(itype(OP_ADDI, 0, 3, 16'(n_t)));  // 8
    prog.push_back(itype(OP_ADDI, 0, 4, 16'd0));     // 12
    prog.push_back(itype(OP_ADDI, 0, 9, 16'd0));     // 16
    prog.push_back(rtype(4, 1, 4, F_ADD));           // 20 loop
    prog.push_back(rtype(1, 2, 1, F_ADD));           // 24
    prog.push_back(itype(OP_ADDI, 9, 9, 16'd1));     // 28
    prog.push_back(itype(OP_BNE, 9, 3, 16'hFFFC));   // 32 -> 20
    prog.push_back(itype(OP_SW, 0, 4, 16'd200));     // 36
    prog.push_back(itype(OP_SW, 0, 9, 16'd204));     // 40
    prog.push_back(itype(OP_LW, 0, 11, 16'd200));    // 44
    prog.push_back(jtype(32'd48));                   // 48
    load_prog();
    wr_base = wr_cnt;
    release_reset();
    run_to_halt(32'd48, 1500, "d_halt");
    check("d_mem50_sum", mem[50], 32'(sum_exp));
    check("d_mem51_n", mem[51], 32'(n_t));
    check("d_r9_n", dut.rf.rf_data[9], 32'(n_t));
    check("d_r11_lw", dut.rf.rf_data[11], 32'(sum_exp));
    check("d_wr_count", 32'(wr_cnt - wr_base), 32'd2);

    // ---- Program E: reset during MEMWR ----
    reset = 1'b1;
    prog.delete();
    prog.push_back(itype(OP_ADDI, 0, 9, 16'd5));
    prog.push_back(itype(OP_SW, 0, 9, 16'd200));
    load_prog();
    load_word(50, 32'hDEADBEEF);
    wr_base = wr_cnt;
    release_reset();
    step(2 * W + 5);
    check("e_pre_state", 32'(dut.state_q), 32'(S_MEMWR));
    reset = 1'b1;
    #1;
    check("e_abort_pc", dut.pc_q, 32'h0);
    check("e_abort_mem_write", {31'd0, mem_write}, 32'd0);
    check("e_abort_mem_read", {31'd0, mem_read}, 32'd0);
    check("e_abort_r9", dut.rf.rf_data[9], 32'd0);
    step(1);
    check("e_mem50_kept", mem[50], 32'hDEADBEEF);
    check("e_wr_count", 32'(wr_cnt - wr_base), 32'd0);

    check("bus_rules", 32'(bus_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
